// File: rtl/soc_run_monitor.sv
// Run supervisor for SoC bring-up: generates the boot-button reset pulse, watches per-core
// retire traffic, emits round-robin heartbeat PC snapshots and latches a sticky verdict.
module soc_run_monitor #(
    parameter int NUM_CORES   = 1,
    parameter int PC_W        = 32,
    parameter int EXCP_W      = 6,
    parameter int PASS_BIT    = 5,
    parameter int RST_DELAY   = 3000,
    parameter int RST_PULSE   = 250,
    parameter int HB_PERIOD   = 10000,
    parameter int STALL_LIMIT = 1000000,
    parameter int TIMEOUT     = 30000000,
    parameter int CNT_W       = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        wb_valid,
    input  logic [NUM_CORES*PC_W-1:0]   wb_pc,
    input  logic [NUM_CORES-1:0]        ws_excp,
    input  logic [NUM_CORES*EXCP_W-1:0] ws_excp_num,
    output logic                        btn_rst,
    output logic                        hb_valid,
    output logic [2:0]                  hb_core,
    output logic [PC_W-1:0]             hb_pc,
    output logic [2:0]                  state,
    output logic                        done,
    output logic                        pass,
    output logic [2:0]                  fail_core,
    output logic [CNT_W-1:0]            cycles
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PULSE   = 3'd1,
        ST_RUN     = 3'd2,
        ST_PASS    = 3'd3,
        ST_STALL   = 3'd4,
        ST_TIMEOUT = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] DLY_LAST   = CNT_W'(RST_DELAY - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] HB_LAST    = CNT_W'(HB_PERIOD - 1);
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [2:0]       LAST_CORE  = 3'(NUM_CORES - 1);

    state_t                 st;
    state_t                 st_nxt;
    logic [CNT_W-1:0]       dly_cnt;
    logic [CNT_W-1:0]       hb_cnt;
    logic [2:0]             hb_sel;
    logic [PC_W-1:0]        hb_src;
    logic [PC_W-1:0]        last_pc  [NUM_CORES];
    logic [CNT_W-1:0]       idle_cnt [NUM_CORES];
    logic [NUM_CORES-1:0]   finished;
    logic [NUM_CORES-1:0]   pass_hit;
    logic [NUM_CORES-1:0]   stall_hit;
    logic                   stall_any;
    logic [2:0]             stall_idx;
    logic                   all_fin;
    logic                   unused_excp;

    // Only the pass bit of each exception number matters here.
    assign unused_excp = ^ws_excp_num;
    assign state       = st;

    always_comb begin
        pass_hit  = '0;
        stall_hit = '0;
        stall_any = 1'b0;
        stall_idx = 3'd0;
        hb_src    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            pass_hit[i]  = wb_valid[i] & ws_excp[i] & ws_excp_num[i*EXCP_W + PASS_BIT];
            stall_hit[i] = !finished[i] && !wb_valid[i] && (idle_cnt[i] == STALL_LAST);
            if (hb_sel == 3'(i)) begin
                hb_src = last_pc[i];
            end
        end
        // Scan downward so the lowest stalled index wins.
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (stall_hit[i]) begin
                stall_any = 1'b1;
                stall_idx = 3'(i);
            end
        end
        all_fin = &(finished | pass_hit);

        st_nxt = st;
        case (st)
            ST_IDLE:  if (dly_cnt == DLY_LAST) st_nxt = ST_PULSE;
            ST_PULSE: if (dly_cnt == PULSE_LAST) st_nxt = ST_RUN;
            ST_RUN: begin
                if (all_fin)                st_nxt = ST_PASS;
                else if (stall_any)         st_nxt = ST_STALL;
                else if (cycles == TO_LAST) st_nxt = ST_TIMEOUT;
            end
            default:  st_nxt = st;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st        <= ST_IDLE;
            dly_cnt   <= '0;
            hb_cnt    <= '0;
            hb_sel    <= 3'd0;
            btn_rst   <= 1'b0;
            hb_valid  <= 1'b0;
            hb_core   <= 3'd0;
            hb_pc     <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_core <= 3'd0;
            cycles    <= '0;
            finished  <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                last_pc[i]  <= '0;
                idle_cnt[i] <= '0;
            end
        end else begin
            st       <= st_nxt;
            done     <= st_nxt inside {ST_PASS, ST_STALL, ST_TIMEOUT};
            pass     <= (st_nxt == ST_PASS);
            btn_rst  <= (st_nxt == ST_PULSE);
            hb_valid <= 1'b0;

            case (st)
                ST_IDLE, ST_PULSE: begin
                    if (st_nxt != st) dly_cnt <= '0;
                    else              dly_cnt <= dly_cnt + 1'b1;
                end
                ST_RUN: begin
                    // The count freezes on the cycle the verdict is taken.
                    if (st_nxt == ST_RUN && cycles != '1) begin
                        cycles <= cycles + 1'b1;
                    end
                    for (int i = 0; i < NUM_CORES; i++) begin
                        if (wb_valid[i]) begin
                            last_pc[i]  <= wb_pc[i*PC_W +: PC_W];
                            idle_cnt[i] <= '0;
                        end else if (!finished[i]) begin
                            idle_cnt[i] <= idle_cnt[i] + 1'b1;
                        end
                        if (pass_hit[i]) finished[i] <= 1'b1;
                    end
                    if (st_nxt == ST_STALL) fail_core <= stall_idx;

                    if (hb_cnt == HB_LAST) begin
                        hb_cnt <= '0;
                        if (st_nxt == ST_RUN) begin
                            hb_valid <= 1'b1;
                            hb_core  <= hb_sel;
                            hb_pc    <= hb_src;
                            hb_sel   <= (hb_sel == LAST_CORE) ? 3'd0 : hb_sel + 3'd1;
                        end
                    end else begin
                        hb_cnt <= hb_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/soc_run_monitor.md
Name: soc_run_monitor

Overview:
- Synthesizable run supervisor for SoC bring-up, on FPGA and in simulation.
- Sits beside the SoC top, one instance per build:
  - generates the boot-button reset pulse on a GPIO input;
  - watches per-core writeback PC, valid and exception signals;
  - emits periodic heartbeat PC snapshots;
  - declares PASS, STALL or TIMEOUT as a sticky verdict.
- Generalises the fixed-delay, single-core, time-based pass/timeout check to N cores, cycle-counted timing, stall detection and an encoded verdict.

Parameters:
- NUM_CORES, 1, number of monitored cores (1..8).
- PC_W, 32, PC width.
- EXCP_W, 6, exception number width.
- PASS_BIT, 5, bit of ws_excp_num marking a pass trap.
- RST_DELAY, 3000, cycles from reset release to button assertion.
- RST_PULSE, 250, cycles the button output stays high.
- HB_PERIOD, 10000, heartbeat interval in cycles.
- STALL_LIMIT, 1000000, cycles without any retire on an unfinished core before STALL.
- TIMEOUT, 30000000, total RUN cycles before TIMEOUT.
- CNT_W, 32, counter width; must hold TIMEOUT.

Ports:
- clock, in, 1: single clock.
- reset, in, 1: synchronous, active-high.
- wb_valid, in, NUM_CORES: per-core retire strobe.
- wb_pc, in, NUM_CORES*PC_W: per-core writeback PC; core i occupies bits [i*PC_W +: PC_W].
- ws_excp, in, NUM_CORES: writeback exception flag.
- ws_excp_num, in, NUM_CORES*EXCP_W: exception number.
- btn_rst, out, 1: drive to gpio_in[0].
- hb_valid, out, 1: one-cycle heartbeat strobe.
- hb_core, out, 3: core index of the heartbeat snapshot.
- hb_pc, out, PC_W: last retired PC of hb_core.
- state, out, 3: IDLE=0, PULSE=1, RUN=2, PASS=3, STALL=4, TIMEOUT=5.
- done, out, 1: high in PASS, STALL or TIMEOUT.
- pass, out, 1: high only in PASS.
- fail_core, out, 3: core that caused STALL; 0 otherwise.
- cycles, out, CNT_W: RUN cycle count, frozen once done.

Behaviour:
- Reset values: state=IDLE, btn_rst=0, hb_valid=0, hb_core=0, hb_pc=0, done=0, pass=0, fail_core=0, cycles=0.
  - All per-core last_pc, finished and idle counters also clear.
- Reset asserted in any state, including terminal ones, returns to IDLE on the next edge.
- IDLE:
  - Delay counter increments each cycle.
  - When it reaches RST_DELAY-1, go to PULSE and clear the counter.
  - btn_rst rises on the cycle state becomes PULSE.
- PULSE:
  - btn_rst=1 for exactly RST_PULSE cycles, then state becomes RUN and btn_rst=0.
  - Retire inputs are ignored in IDLE and PULSE.
- RUN:
  - cycles increments every RUN cycle and saturates at all-ones.
  - Per core i, when wb_valid[i]=1: last_pc[i] is set to the wb_pc slice and idle counter i clears. Otherwise idle counter i increments while finished[i]=0.
  - Pass trap: wb_valid[i] & ws_excp[i] & ws_excp_num[i][PASS_BIT] sets finished[i], sticky.
  - When all finished bits are 1 (including ones set this cycle), next state is PASS.
  - If any unfinished core's idle counter equals STALL_LIMIT-1 and it does not retire this cycle, next state is STALL.
    - fail_core is the lowest such index.
  - If cycles equals TIMEOUT-1, next state is TIMEOUT.
  - Priority on the same cycle: PASS > STALL > TIMEOUT.
- Heartbeat (RUN only):
  - Heartbeat counter wraps every HB_PERIOD cycles.
  - At wrap: hb_valid=1 for one cycle, hb_pc=last_pc[hb_core]; hb_core then advances round-robin 0..NUM_CORES-1.
  - hb_pc holds its value between strobes.
  - No heartbeat in terminal states.
- Terminal states (PASS, STALL, TIMEOUT):
  - Absorbing until reset.
  - cycles and fail_core frozen; done=1; pass=(state==PASS).
- All outputs are registered; the verdict appears one cycle after the triggering retire.

Test Plan:
- NUM_CORES=1, RST_DELAY=10, RST_PULSE=5:
  - btn_rst high exactly cycles 10..14 after reset release, state=RUN at cycle 15.
  - Core retires pc=0x1c000000+4k; at cycle k=20 it retires with ws_excp=1, ws_excp_num=6'h20.
  - Next cycle: state=PASS, pass=1, done=1; cycles frozen.
- NUM_CORES=2, STALL_LIMIT=50:
  - Core 0 passes early; core 1 stops retiring.
  - Required: STALL exactly 50 cycles after core 1's last retire, fail_core=1, pass=0.
- TIMEOUT=200, continuous retires with no pass trap:
  - Required: state=TIMEOUT with cycles=199 held, done=1, pass=0.
- HB_PERIOD=16, NUM_CORES=2, core0 pc=0x100, core1 pc=0x200 held:
  - Required: hb_valid every 16 cycles, alternating hb_core=0/hb_pc=0x100 and hb_core=1/hb_pc=0x200.
- Same-cycle conflict:
  - Final pass trap lands on the cycle cycles=TIMEOUT-1 → required: state=PASS.
  - ws_excp with ws_excp_num[5]=0 → required: no finish.
- Reset mid-PULSE and in STALL:
  - Required: next edge state=IDLE, btn_rst=0, all counters and outputs at reset values.
  - The full delay/pulse sequence then repeats.
